// File: rtl/mem_load_sequencer.sv
// Frame parser for the DSP memory-load path: header, length and payload words
// become registered write strobes with auto-incrementing address and frame checks.
module mem_load_sequencer #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned LENWIDTH  = 16,
    parameter int unsigned NPROC     = 3,
    parameter int unsigned NMEMSEL   = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DATAWIDTH-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [DATAWIDTH-1:0] mem_write_data,
    output logic [ADDRWIDTH-1:0] mem_write_addr,
    output logic [2:0]           proc_write_sel,
    output logic [2:0]           mem_write_sel,
    output logic                 mem_write_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          frame_count
);

    typedef enum logic [1:0] {IDLE, LEN, DATA, DRAIN} state_t;

    state_t                state, next_state;
    logic [2:0]            proc_q, mem_q;
    logic [ADDRWIDTH-1:0]  start_q, addr_q;
    logic [LENWIDTH-1:0]   remaining_q;
    logic                  bad_q;

    logic                  accept;
    logic [2:0]            hdr_proc, hdr_mem;
    logic [ADDRWIDTH-1:0]  hdr_addr;
    logic                  hdr_bad;
    logic [LENWIDTH-1:0]   len_n;
    logic                  latch_hdr, load_len, data_beat, wr_fire, done_set, err_set;

    assign accept   = s_valid & s_ready;
    assign hdr_proc = s_data[2:0];
    assign hdr_mem  = s_data[5:3];
    assign hdr_addr = s_data[6 +: ADDRWIDTH];
    assign hdr_bad  = (32'(hdr_proc) >= NPROC) | (32'(hdr_mem) >= NMEMSEL);
    assign len_n    = s_data[LENWIDTH-1:0];
    assign busy     = (state != IDLE);

    always_comb begin
        next_state = state;
        latch_hdr  = 1'b0;
        load_len   = 1'b0;
        data_beat  = 1'b0;
        wr_fire    = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    latch_hdr = 1'b1;
                    if (s_last) err_set = 1'b1;
                    else        next_state = LEN;
                end
                LEN: begin
                    load_len = 1'b1;
                    if (len_n == '0) begin
                        if (s_last) begin
                            done_set   = ~bad_q;
                            err_set    = bad_q;
                            next_state = IDLE;
                        end else begin
                            err_set    = 1'b1;
                            next_state = DRAIN;
                        end
                    end else if (s_last) begin
                        err_set    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = DATA;
                    end
                end
                DATA: begin
                    data_beat = 1'b1;
                    wr_fire   = ~bad_q;
                    if (remaining_q == LENWIDTH'(1)) begin
                        if (s_last) begin
                            done_set   = ~bad_q;
                            err_set    = bad_q;
                            next_state = IDLE;
                        end else begin
                            err_set    = 1'b1;
                            next_state = DRAIN;
                        end
                    end else if (s_last) begin
                        // truncated frame: the current word is still written
                        err_set    = 1'b1;
                        next_state = IDLE;
                    end
                end
                DRAIN: begin
                    if (s_last) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            s_ready        <= 1'b0;
            proc_q         <= '0;
            mem_q          <= '0;
            start_q        <= '0;
            addr_q         <= '0;
            remaining_q    <= '0;
            bad_q          <= 1'b0;
            mem_write_data <= '0;
            mem_write_addr <= '0;
            proc_write_sel <= '0;
            mem_write_sel  <= '0;
            mem_write_en   <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            frame_count    <= '0;
        end else begin
            state   <= next_state;
            s_ready <= 1'b1;
            if (latch_hdr) begin
                proc_q  <= hdr_proc;
                mem_q   <= hdr_mem;
                start_q <= hdr_addr;
                bad_q   <= hdr_bad;
            end
            if (load_len) begin
                remaining_q <= len_n;
                addr_q      <= start_q;
            end
            if (data_beat) begin
                remaining_q <= remaining_q - LENWIDTH'(1);
                addr_q      <= addr_q + ADDRWIDTH'(1);
            end
            mem_write_en <= wr_fire;
            if (wr_fire) begin
                mem_write_data <= s_data;
                mem_write_addr <= addr_q;
                proc_write_sel <= proc_q;
                mem_write_sel  <= mem_q;
            end
            done <= done_set;
            err  <= err_set;
            if (done_set) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Directed bench for mem_load_sequencer: frames driven beat by beat, writes and
// pulses captured on the falling edge and compared against hand-built expectations.
module tb_mem_load_sequencer;

    typedef struct packed {
        logic [31:0] d;
        logic [15:0] a;
        logic [2:0]  p;
        logic [2:0]  m;
    } wr_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] mem_write_data;
    logic [15:0] mem_write_addr;
    logic [2:0]  proc_write_sel, mem_write_sel;
    logic        mem_write_en, busy, done, err;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    wr_t wr_q[$];
    wr_t exp_q[$];
    int  wr_base = 0;
    int  done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int  done_base = 0, err_base = 0;

    mem_load_sequencer #(
        .DATAWIDTH(32), .ADDRWIDTH(16), .LENWIDTH(16), .NPROC(3), .NMEMSEL(3)
    ) dut (
        .clk(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .mem_write_data(mem_write_data),
        .mem_write_addr(mem_write_addr), .proc_write_sel(proc_write_sel),
        .mem_write_sel(mem_write_sel), .mem_write_en(mem_write_en), .busy(busy),
        .done(done), .err(err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn) begin
            if (mem_write_en) wr_q.push_back({mem_write_data, mem_write_addr, proc_write_sel, mem_write_sel});
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (done && err) both_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [2:0] p, input logic [2:0] m, input logic [15:0] a);
        return {10'b0, a, m, p};
    endfunction

    // Present one beat after `gap` idle cycles; returns #1 after the accepting edge.
    task automatic beat(input logic [31:0] d, input logic l, input int gap);
        int tries;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        tries = 0;
        while (!s_ready && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!s_ready) check_eq("s_ready_timeout", 32'(s_ready), 32'd1);
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] d, input logic [15:0] a, input logic [2:0] p, input logic [2:0] m);
        exp_q.push_back({d, a, p, m});
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic verify_writes(input string tag);
        check_eq({tag, "_nwr"}, 32'(wr_q.size() - wr_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wr_base + i < wr_q.size()) begin
                check_eq($sformatf("%s_d%0d", tag, i), wr_q[wr_base+i].d, exp_q[i].d);
                check_eq($sformatf("%s_a%0d", tag, i), 32'(wr_q[wr_base+i].a), 32'(exp_q[i].a));
                check_eq($sformatf("%s_p%0d", tag, i), 32'(wr_q[wr_base+i].p), 32'(exp_q[i].p));
                check_eq($sformatf("%s_m%0d", tag, i), 32'(wr_q[wr_base+i].m), 32'(exp_q[i].m));
            end
        end
        wr_base = wr_q.size();
        exp_q.delete();
    endtask

    task automatic verify_pulses(input string tag, input int exp_done, input int exp_err);
        check_eq({tag, "_done"}, 32'(done_cnt - done_base), 32'(exp_done));
        check_eq({tag, "_err"}, 32'(err_cnt - err_base), 32'(exp_err));
        done_base = done_cnt;
        err_base  = err_cnt;
    endtask

    initial begin
        int gaps[4];
        gaps = '{2, 0, 3, 1};

        #12;
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_wr_en", 32'(mem_write_en), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_fcount", 32'(frame_count), 32'd0);
        check_eq("rst_addr", 32'(mem_write_addr), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_rst", 32'(s_ready), 32'd1);

        // basic frame
        beat(hdr(3'd1, 3'd2, 16'h0010), 1'b0, 0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        beat(32'd4, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            beat(32'hA0 + 32'(i), (i == 3), 0);
            check_eq($sformatf("t1_lat_en%0d", i), 32'(mem_write_en), 32'd1);
            expect_wr(32'hA0 + 32'(i), 16'h0010 + 16'(i), 3'd1, 3'd2);
        end
        check_eq("t1_done_aligned", 32'(done), 32'd1);
        check_eq("t1_idle", 32'(busy), 32'd0);
        settle();
        verify_writes("t1");
        verify_pulses("t1", 1, 0);
        check_eq("t1_fcount", 32'(frame_count), 32'd1);

        // same frame with gaps, then a back-to-back frame
        beat(hdr(3'd1, 3'd2, 16'h0010), 1'b0, 1);
        beat(32'd4, 1'b0, 2);
        for (int i = 0; i < 4; i++) begin
            beat(32'hA0 + 32'(i), (i == 3), gaps[i]);
            expect_wr(32'hA0 + 32'(i), 16'h0010 + 16'(i), 3'd1, 3'd2);
        end
        check_eq("t2_done", 32'(done), 32'd1);
        check_eq("t2_ready_at_done", 32'(s_ready), 32'd1);
        beat(hdr(3'd0, 3'd0, 16'h0000), 1'b0, 0);
        check_eq("t2_nobubble_busy", 32'(busy), 32'd1);
        beat(32'd1, 1'b0, 0);
        beat(32'h55, 1'b1, 0);
        expect_wr(32'h55, 16'h0000, 3'd0, 3'd0);
        settle();
        verify_writes("t2");
        verify_pulses("t2", 2, 0);
        check_eq("t2_fcount", 32'(frame_count), 32'd3);

        // bad proc select
        beat(hdr(3'd3, 3'd0, 16'h0020), 1'b0, 0);
        beat(32'd2, 1'b0, 0);
        beat(32'h11, 1'b0, 0);
        beat(32'h22, 1'b1, 0);
        check_eq("t3_err", 32'(err), 32'd1);
        check_eq("t3_idle", 32'(busy), 32'd0);
        settle();
        verify_writes("t3");
        verify_pulses("t3", 0, 1);
        check_eq("t3_fcount", 32'(frame_count), 32'd3);

        // address wrap
        beat(hdr(3'd0, 3'd1, 16'hFFFE), 1'b0, 0);
        beat(32'd3, 1'b0, 0);
        beat(32'hC0, 1'b0, 0);
        beat(32'hC1, 1'b0, 0);
        beat(32'hC2, 1'b1, 0);
        expect_wr(32'hC0, 16'hFFFE, 3'd0, 3'd1);
        expect_wr(32'hC1, 16'hFFFF, 3'd0, 3'd1);
        expect_wr(32'hC2, 16'h0000, 3'd0, 3'd1);
        settle();
        verify_writes("t4");
        verify_pulses("t4", 1, 0);
        check_eq("t4_fcount", 32'(frame_count), 32'd4);

        // zero-length frame
        beat(hdr(3'd2, 3'd2, 16'h0123), 1'b0, 0);
        beat(32'd0, 1'b1, 0);
        settle();
        verify_writes("t4z");
        verify_pulses("t4z", 1, 0);
        check_eq("t4z_fcount", 32'(frame_count), 32'd5);

        // truncated frame
        beat(hdr(3'd2, 3'd0, 16'h0100), 1'b0, 0);
        beat(32'd4, 1'b0, 0);
        beat(32'hB0, 1'b0, 0);
        beat(32'hB1, 1'b1, 0);
        expect_wr(32'hB0, 16'h0100, 3'd2, 3'd0);
        expect_wr(32'hB1, 16'h0101, 3'd2, 3'd0);
        check_eq("t5a_err", 32'(err), 32'd1);
        settle();
        verify_writes("t5a");
        verify_pulses("t5a", 0, 1);

        // overlong frame drained, then a normal frame
        beat(hdr(3'd1, 3'd1, 16'h0200), 1'b0, 0);
        beat(32'd2, 1'b0, 0);
        beat(32'hD0, 1'b0, 0);
        beat(32'hD1, 1'b0, 0);
        check_eq("t5b_err", 32'(err), 32'd1);
        check_eq("t5b_drain_busy", 32'(busy), 32'd1);
        beat(32'hE0, 1'b0, 0);
        beat(32'hE1, 1'b0, 0);
        beat(32'hE2, 1'b1, 0);
        check_eq("t5b_drain_exit", 32'(busy), 32'd0);
        beat(hdr(3'd2, 3'd2, 16'h0300), 1'b0, 0);
        beat(32'd1, 1'b0, 0);
        beat(32'hF5, 1'b1, 0);
        expect_wr(32'hD0, 16'h0200, 3'd1, 3'd1);
        expect_wr(32'hD1, 16'h0201, 3'd1, 3'd1);
        expect_wr(32'hF5, 16'h0300, 3'd2, 3'd2);
        settle();
        verify_writes("t5b");
        verify_pulses("t5b", 1, 1);
        check_eq("t5b_fcount", 32'(frame_count), 32'd6);

        // reset mid-frame: the second word's strobe is cut by the reset
        beat(hdr(3'd0, 3'd2, 16'h0040), 1'b0, 0);
        beat(32'd8, 1'b0, 0);
        beat(32'h70, 1'b0, 0);
        beat(32'h71, 1'b0, 0);
        check_eq("t6_en_before", 32'(mem_write_en), 32'd1);
        resetn = 1'b0;
        #1;
        check_eq("t6_en_async", 32'(mem_write_en), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_done", 32'(done), 32'd0);
        check_eq("t6_err", 32'(err), 32'd0);
        check_eq("t6_fcount", 32'(frame_count), 32'd0);
        expect_wr(32'h70, 16'h0040, 3'd0, 3'd2);
        @(negedge clk);
        resetn = 1'b1;
        beat(hdr(3'd1, 3'd0, 16'h0050), 1'b0, 0);
        beat(32'd2, 1'b0, 0);
        beat(32'h80, 1'b0, 0);
        beat(32'h81, 1'b1, 0);
        expect_wr(32'h80, 16'h0050, 3'd1, 3'd0);
        expect_wr(32'h81, 16'h0051, 3'd1, 3'd0);
        settle();
        verify_writes("t6");
        verify_pulses("t6", 1, 0);
        check_eq("t6_fcount_after", 32'(frame_count), 32'd1);

        check_eq("done_err_exclusive", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
